// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: unit-select codes,
// opcode field positions and the sequencer FSM state encoding.
package alu_seq_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam int OPC_UNIT_HI = 3;
    localparam int OPC_UNIT_LO = 2;
    localparam int OPC_FUN_HI  = 1;
    localparam int OPC_FUN_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

    // Bit order of the returned vector: {shift, cmp, logic, arith}
    function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
        return 4'b0001 << unit;
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Combinational 4:1 select of the execution units' {OUT, Flag} pairs,
// steered by the sequencer's latched unit-select register.
module alu_result_mux
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]         sel,
    input  logic [2*WIDTH-1:0] arith_out,
    input  logic               arith_flag,
    input  logic [2*WIDTH-1:0] logic_out,
    input  logic               logic_flag,
    input  logic [2*WIDTH-1:0] cmp_out,
    input  logic               cmp_flag,
    input  logic [2*WIDTH-1:0] shift_out,
    input  logic               shift_flag,
    output logic [2*WIDTH-1:0] out,
    output logic               flag
);

    always_comb begin
        out  = '0;
        flag = 1'b0;
        case (sel)
            UNIT_ARITH: begin out = arith_out; flag = arith_flag; end
            UNIT_LOGIC: begin out = logic_out; flag = logic_flag; end
            UNIT_CMP:   begin out = cmp_out;   flag = cmp_flag;   end
            UNIT_SHIFT: begin out = shift_out; flag = shift_flag; end
            default:    begin out = '0;        flag = 1'b0;       end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the ALU units: accept, issue one-cycle enable, wait for flag, return result.
// Optional WAIT timeout is compiled in with ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [3:0]         CMD_OPC,
    input  logic [WIDTH-1:0]   CMD_A,
    input  logic [WIDTH-1:0]   CMD_B,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic [1:0]         ALU_FUN,
    output logic               Arith_Enable,
    output logic               Logic_Enable,
    output logic               CMP_Enable,
    output logic               Shift_Enable,
    input  logic [2*WIDTH-1:0] Arith_OUT,
    input  logic [2*WIDTH-1:0] Logic_OUT,
    input  logic [2*WIDTH-1:0] CMP_OUT,
    input  logic [2*WIDTH-1:0] SHIFT_OUT,
    input  logic               Arith_Flag,
    input  logic               Logic_Flag,
    input  logic               CMP_Flag,
    input  logic               SHIFT_Flag,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [2*WIDTH-1:0] RES_DATA,
    output logic [1:0]         RES_UNIT,
    output logic               RES_ERR
);

    seq_state_e         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         fun_q, fun_d;
    logic [1:0]         unit_q, unit_d;
    logic [2*WIDTH-1:0] res_data_q, res_data_d;
    logic [1:0]         res_unit_q, res_unit_d;
    logic               res_err_q, res_err_d;
    logic [3:0]         enable;
    logic               cmd_ready;
    logic               res_valid;
    logic [2*WIDTH-1:0] sel_out;
    logic               sel_flag;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    alu_result_mux #(.WIDTH(WIDTH)) u_result_mux (
        .sel        (unit_q),
        .arith_out  (Arith_OUT),
        .arith_flag (Arith_Flag),
        .logic_out  (Logic_OUT),
        .logic_flag (Logic_Flag),
        .cmp_out    (CMP_OUT),
        .cmp_flag   (CMP_Flag),
        .shift_out  (SHIFT_OUT),
        .shift_flag (SHIFT_Flag),
        .out        (sel_out),
        .flag       (sel_flag)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        unit_d     = unit_q;
        res_data_d = res_data_q;
        res_unit_d = res_unit_q;
        res_err_d  = res_err_q;
        enable     = 4'b0000;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (CMD_VALID) begin
                    a_d     = CMD_A;
                    b_d     = CMD_B;
                    fun_d   = CMD_OPC[OPC_FUN_HI:OPC_FUN_LO];
                    unit_d  = CMD_OPC[OPC_UNIT_HI:OPC_UNIT_LO];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                enable  = unit_onehot(unit_q);
                state_d = ST_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                // A flag arriving on the final timeout cycle still counts as a real result
                if (sel_flag) begin
                    res_data_d = sel_out;
                    res_unit_d = unit_q;
                    res_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_data_d = '0;
                    res_unit_d = unit_q;
                    res_err_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (RES_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            unit_q     <= '0;
            res_data_q <= '0;
            res_unit_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            unit_q     <= unit_d;
            res_data_q <= res_data_d;
            res_unit_q <= res_unit_d;
            res_err_q  <= res_err_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign CMD_READY    = cmd_ready;
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign Arith_Enable = enable[0];
    assign Logic_Enable = enable[1];
    assign CMP_Enable   = enable[2];
    assign Shift_Enable = enable[3];
    assign RES_VALID    = res_valid;
    assign RES_DATA     = res_data_q;
    assign RES_UNIT     = res_unit_q;
    assign RES_ERR      = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with simple registered unit models.
// Covers both builds (with and without ALU_SEQ_TIMEOUT_EN).
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [3:0]  CMD_OPC = 4'h0;
    logic [15:0] CMD_A = 16'h0, CMD_B = 16'h0;
    logic [15:0] A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [31:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, SHIFT_OUT = '0;
    logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, SHIFT_Flag = 1'b0;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic [31:0] RES_DATA;
    logic [1:0]  RES_UNIT;
    logic        RES_ERR;

    logic        arith_mute = 1'b0, cmp_mute = 1'b0, force_shift = 1'b0;
    int          logic_dly = 0;
    int          lcnt = 0;
    int          n_tests = 0, n_fail = 0;
    int          cyc;

    alu_op_sequencer #(.WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OPC(CMD_OPC),
        .CMD_A(CMD_A), .CMD_B(CMD_B),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_UNIT(RES_UNIT), .RES_ERR(RES_ERR)
    );

    always #5 clk = ~clk;

    // Registered unit models
    always @(posedge clk) begin
        Arith_OUT  <= 32'(A) + 32'(B);
        Arith_Flag <= Arith_Enable & ~arith_mute;
        CMP_OUT    <= (A > B) ? 32'd1 : 32'd0;
        CMP_Flag   <= CMP_Enable & ~cmp_mute;
        Logic_OUT  <= 32'(A & B);
        SHIFT_Flag <= Shift_Enable | force_shift;
        case (ALU_FUN)
            2'd0:    SHIFT_OUT <= 32'(A) >> 1;
            2'd1:    SHIFT_OUT <= 32'(A) << 1;
            2'd2:    SHIFT_OUT <= 32'(B) >> 1;
            default: SHIFT_OUT <= 32'(B) << 1;
        endcase
        Logic_Flag <= 1'b0;
        if (Logic_Enable) begin
            if (logic_dly == 0) Logic_Flag <= 1'b1;
            else lcnt <= logic_dly;
        end else if (lcnt > 0) begin
            lcnt <= lcnt - 1;
            if (lcnt == 1) Logic_Flag <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command in IDLE; returns one step after the accept edge (in ISSUE)
    task automatic send(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
        CMD_VALID = 1'b1;
        CMD_OPC   = opc;
        CMD_A     = a;
        CMD_B     = b;
        tick();
        CMD_VALID = 1'b0;
    endtask

    // Cycles from the accept edge until RES_VALID, bounded
    task automatic wait_res(output int n);
        n = 1;
        tick();
        while (!RES_VALID && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic release_res();
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        // Reset state
        check("rst_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, 4'b0);
        check("rst_ab", {A, B, ALU_FUN}, 34'h0);
        check("rst_res", {RES_VALID, RES_ERR, RES_UNIT, RES_DATA}, 36'h0);
        RST = 1'b1;
        #1;
        check("rst_rdy", CMD_READY, 1'b1);

        // Reset in the middle of WAIT
        arith_mute = 1'b1;
        send(4'b0000, 16'h0011, 16'h0022);
        tick();
        tick();
        check("wait_rdy", {CMD_READY, RES_VALID}, 2'b00);
        RST = 1'b0;
        #1;
        check("mid_rst_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, 4'b0);
        check("mid_rst_vld", RES_VALID, 1'b0);
        tick();
        RST = 1'b1;
        #1;
        check("mid_rst_rdy", CMD_READY, 1'b1);
        arith_mute = 1'b0;
        tick();

        // Shift A>>1
        send(4'b1100, 16'h8001, 16'h0000);
        check("sh_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, 4'b0001);
        check("issue_rdy", CMD_READY, 1'b0);
        wait_res(cyc);
        check("sh_lat", cyc, 2);
        check("sh_data", RES_DATA, 32'h0000_4000);
        check("sh_unit", RES_UNIT, 2'd3);
        check("sh_err", RES_ERR, 1'b0);
        release_res();
        check("sh_idle", {CMD_READY, RES_VALID}, 2'b10);

        // Shift B<<1 without truncation, then backpressure on the result
        send(4'b1111, 16'h0000, 16'h8001);
        wait_res(cyc);
        check("shb_data", RES_DATA, 32'h0001_0002);
        CMD_VALID = 1'b1;
        CMD_OPC   = 4'b0000;
        CMD_A     = 16'h0003;
        CMD_B     = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_vld", {RES_VALID, CMD_READY}, 2'b10);
            check("bp_data", RES_DATA, 32'h0001_0002);
        end
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        check("bp_exit", {CMD_READY, RES_VALID, Arith_Enable}, 3'b100);
        check("bp_hold", RES_DATA, 32'h0001_0002);
        tick();
        CMD_VALID = 1'b0;
        check("bp_accept", Arith_Enable, 1'b1);
        wait_res(cyc);
        check("ar_data", RES_DATA, 32'd7);
        check("ar_unit", RES_UNIT, 2'd0);
        release_res();

        // Compare unit
        send(4'b1000, 16'h0005, 16'h0003);
        wait_res(cyc);
        check("cmp_data", {RES_UNIT, RES_DATA}, {2'd2, 32'd1});
        release_res();

        // Logic with delayed flag while SHIFT_Flag is stuck high
        force_shift = 1'b1;
        logic_dly   = 3;
        send(4'b0101, 16'hF0F0, 16'h3C3C);
        check("lg_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, 4'b0100);
        wait_res(cyc);
        check("lg_lat", cyc, 5);
        check("lg_data", RES_DATA, 32'h0000_3030);
        check("lg_unit", RES_UNIT, 2'd1);
        check("lg_fun", {ALU_FUN, A}, {2'd1, 16'hF0F0});
        release_res();
        force_shift = 1'b0;
        logic_dly   = 0;

        // Selected flag never arrives
        cmp_mute = 1'b1;
        send(4'b1000, 16'h0009, 16'h0001);
`ifdef ALU_SEQ_TIMEOUT_EN
        wait_res(cyc);
        check("to_lat", cyc, 9);
        check("to_err", {RES_VALID, RES_ERR}, 2'b11);
        check("to_data", RES_DATA, 32'h0);
        check("to_unit", RES_UNIT, 2'd2);
        release_res();
        check("to_idle", CMD_READY, 1'b1);
`else
        for (int i = 0; i < 20; i++) tick();
        check("nto_vld", {RES_VALID, CMD_READY, RES_ERR}, 3'b000);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        check("nto_rst", CMD_READY, 1'b1);
`endif
        cmp_mute = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
